// File: rtl/ahb_burst_seq.sv
// Burst address sequencer: expands one AHB burst request into per-beat address phases.
// Optional macro AHB_BURST_SEQ_1KB_SPLIT_EN restarts INCR bursts as NONSEQ at 1 KB crossings.
module ahb_burst_seq #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MAX_LEN = 8,
   parameter int unsigned LEN_W   = $clog2(MAX_LEN) + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [1:0]          req_incr,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [LEN_W-1:0]    req_len,
   input  logic [DATA_W/8-1:0] req_byte_sel,
   output logic                beat_valid,
   input  logic                beat_ready,
   output logic [ADDR_W-1:0]   beat_addr,
   output logic                beat_write,
   output logic [DATA_W/8-1:0] beat_byte_sel,
   output logic                beat_first,
   output logic                beat_last,
   output logic [LEN_W-1:0]    beat_idx,
   output logic                req_err
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned SHIFT  = $clog2(STRB_W);

   localparam logic [1:0] INCR_FIXED = 2'd0;
   localparam logic [1:0] INCR_INCR  = 2'd1;
   localparam logic [1:0] INCR_WRAP  = 2'd2;
   localparam logic [1:0] INCR_RSVD  = 2'd3;

   typedef enum logic {StIdle, StBurst} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LEN_W-1:0]    idx_q, idx_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [1:0]          incr_q, incr_d;
   logic                write_q, write_d;
   logic [STRB_W-1:0]   bsel_q, bsel_d;
   logic                first_q, first_d;
   logic                err_q, err_d;

   logic                req_hs, beat_hs, req_legal, is_last;
   logic                len_ok, incr_ok, wrap_ok, align_ok;
   logic [ADDR_W-1:0]   wrap_mask, incr_addr, next_addr;

   // Request legality
   always_comb begin
      len_ok    = (req_len != '0) && (req_len <= LEN_W'(MAX_LEN));
      incr_ok   = (req_incr != INCR_RSVD);
      wrap_ok   = (req_incr != INCR_WRAP) || ((req_len & (req_len - LEN_W'(1))) == '0);
      align_ok  = ((req_addr & ADDR_W'(STRB_W - 1)) == '0);
      req_legal = len_ok && incr_ok && wrap_ok && align_ok;
   end

   // Beat address advance; wrap mask is the burst footprint len*S minus one
   always_comb begin
      wrap_mask = (ADDR_W'(len_q) << SHIFT) - ADDR_W'(1);
      incr_addr = addr_q + ADDR_W'(STRB_W);
      unique case (incr_q)
         INCR_FIXED: next_addr = addr_q;
         INCR_INCR:  next_addr = incr_addr;
         INCR_WRAP:  next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
         default:    next_addr = addr_q;
      endcase
   end

   assign req_hs  = req_valid & req_ready;
   assign beat_hs = beat_valid & beat_ready;
   assign is_last = (idx_q == len_q - LEN_W'(1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (req_hs && req_legal) state_d = StBurst;
         StBurst: if (beat_hs && is_last)  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output logic
   always_comb begin
      req_ready     = (state_q == StIdle);
      beat_valid    = (state_q == StBurst);
      beat_first    = beat_valid & first_q;
      beat_last     = beat_valid & is_last;
      beat_addr     = addr_q;
      beat_idx      = idx_q;
      beat_write    = write_q;
      beat_byte_sel = bsel_q;
      req_err       = err_q;
   end

   // Datapath next-state
   always_comb begin
      addr_d  = addr_q;
      idx_d   = idx_q;
      len_d   = len_q;
      incr_d  = incr_q;
      write_d = write_q;
      bsel_d  = bsel_q;
      first_d = first_q;
      err_d   = 1'b0;
      if (req_hs) begin
         if (req_legal) begin
            addr_d  = req_addr;
            idx_d   = '0;
            len_d   = req_len;
            incr_d  = req_incr;
            write_d = req_write;
            bsel_d  = req_byte_sel;
            first_d = 1'b1;
         end else begin
            err_d = 1'b1;
         end
      end
      if (beat_hs) begin
         addr_d  = next_addr;
         idx_d   = idx_q + LEN_W'(1);
         first_d = 1'b0;
`ifdef AHB_BURST_SEQ_1KB_SPLIT_EN
         if ((incr_q == INCR_INCR) && ((next_addr & ADDR_W'(10'h3FF)) == '0) && !is_last) begin
            first_d = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         idx_q   <= '0;
         len_q   <= '0;
         incr_q  <= INCR_FIXED;
         write_q <= 1'b0;
         bsel_q  <= '0;
         first_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         incr_q  <= incr_d;
         write_q <= write_d;
         bsel_q  <= bsel_d;
         first_q <= first_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_ahb_burst_seq.sv
// Directed, table-driven bench for ahb_burst_seq (ADDR_W=32, DATA_W=32, MAX_LEN=8).
module tb_ahb_burst_seq;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_incr;
   logic [31:0] req_addr;
   logic [3:0]  req_len;
   logic [3:0]  req_byte_sel;
   logic        beat_valid;
   logic        beat_ready;
   logic [31:0] beat_addr;
   logic        beat_write;
   logic [3:0]  beat_byte_sel;
   logic        beat_first;
   logic        beat_last;
   logic [3:0]  beat_idx;
   logic        req_err;

   int checks = 0;
   int errors = 0;

   ahb_burst_seq #(
      .ADDR_W (32),
      .DATA_W (32),
      .MAX_LEN(8),
      .LEN_W  (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_incr     (req_incr),
      .req_addr     (req_addr),
      .req_len      (req_len),
      .req_byte_sel (req_byte_sel),
      .beat_valid   (beat_valid),
      .beat_ready   (beat_ready),
      .beat_addr    (beat_addr),
      .beat_write   (beat_write),
      .beat_byte_sel(beat_byte_sel),
      .beat_first   (beat_first),
      .beat_last    (beat_last),
      .beat_idx     (beat_idx),
      .req_err      (req_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic             write;
      logic [1:0]       incr;
      logic [31:0]      addr;
      logic [3:0]       len;
      logic [3:0]       bsel;
      logic             err;
      logic [7:0]       first;
      logic [15:0]      rdy;
      logic [7:0][31:0] exp;
   } vec_t;

   localparam int NV = 14;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0][31:0] a8(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
      return {a7, a6, a5, a4, a3, a2, a1, a0};
   endfunction

   function automatic vec_t mk(input logic w, input logic [1:0] inc, input logic [31:0] a,
                               input logic [3:0] l, input logic [3:0] bs, input logic e,
                               input logic [7:0] f, input logic [15:0] r,
                               input logic [7:0][31:0] x);
      vec_t v;
      v.write = w; v.incr = inc; v.addr = a; v.len = l; v.bsel = bs;
      v.err = e; v.first = f; v.rdy = r; v.exp = x;
      return v;
   endfunction

   // Called and returns on a negative clock edge.
   task automatic run_vec(input vec_t v);
      int b;
      int cyc;
      req_valid    = 1'b1;
      req_write    = v.write;
      req_incr     = v.incr;
      req_addr     = v.addr;
      req_len      = v.len;
      req_byte_sel = v.bsel;
      chk("req_ready_idle", req_ready, 1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_incr  = 2'd3;
      req_len   = 4'd0;
      req_addr  = 32'h0000_0003;
      if (v.err) begin
         chk("err_pulse", req_err, 1);
         chk("err_no_beat", beat_valid, 0);
         chk("err_ready", req_ready, 1);
         @(posedge clk);
         @(negedge clk);
         chk("err_once", req_err, 0);
         chk("err_no_beat2", beat_valid, 0);
      end else begin
         chk("no_err", req_err, 0);
         b = 0;
         cyc = 0;
         while (b < int'(v.len) && cyc < 40) begin
            chk("beat_valid", beat_valid, 1);
            chk("ready_busy", req_ready, 0);
            chk("beat_addr", beat_addr, v.exp[b]);
            chk("beat_idx", beat_idx, 64'(b));
            chk("beat_first", beat_first, v.first[b]);
            chk("beat_last", beat_last, (b == int'(v.len) - 1) ? 1 : 0);
            chk("beat_write", beat_write, v.write);
            chk("beat_bsel", beat_byte_sel, v.bsel);
            beat_ready = v.rdy[cyc % 16];
            @(posedge clk);
            if (beat_ready) b++;
            cyc++;
            @(negedge clk);
         end
         if (cyc >= 40) chk("beat_timeout", 0, 1);
         beat_ready = 1'b1;
         chk("done_valid", beat_valid, 0);
         chk("done_ready", req_ready, 1);
      end
   endtask

   initial begin
      logic [7:0] split_first;
`ifdef AHB_BURST_SEQ_1KB_SPLIT_EN
      split_first = 8'b0000_0101;
`else
      split_first = 8'b0000_0001;
`endif
      //                 w     incr   addr           len   bsel  err   first         rdy
      vecs[0]  = mk(1'b1, 2'd1, 32'h0000_0100, 4'd4, 4'hF, 1'b0, 8'h01,       16'hFFFF,
                    a8(32'h100, 32'h104, 32'h108, 32'h10C, 0, 0, 0, 0));
      vecs[1]  = mk(1'b0, 2'd2, 32'h0000_0038, 4'd4, 4'h3, 1'b0, 8'h01,       16'hFFFF,
                    a8(32'h38, 32'h3C, 32'h30, 32'h34, 0, 0, 0, 0));
      vecs[2]  = mk(1'b1, 2'd1, 32'h0000_0100, 4'd8, 4'hC, 1'b0, 8'h01,       16'hFFF9,
                    a8(32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114, 32'h118, 32'h11C));
      vecs[3]  = mk(1'b1, 2'd0, 32'h0000_0040, 4'd3, 4'h1, 1'b0, 8'h01,       16'hFFFF,
                    a8(32'h40, 32'h40, 32'h40, 0, 0, 0, 0, 0));
      vecs[4]  = mk(1'b0, 2'd1, 32'hFFFF_FFFC, 4'd2, 4'hF, 1'b0, 8'h01,       16'hFFFF,
                    a8(32'hFFFF_FFFC, 32'h0, 0, 0, 0, 0, 0, 0));
      vecs[5]  = mk(1'b0, 2'd2, 32'h0000_0014, 4'd8, 4'h6, 1'b0, 8'h01,       16'h5555,
                    a8(32'h14, 32'h18, 32'h1C, 32'h00, 32'h04, 32'h08, 32'h0C, 32'h10));
      vecs[6]  = mk(1'b1, 2'd1, 32'h0000_03F8, 4'd4, 4'hF, 1'b0, split_first, 16'hFFFF,
                    a8(32'h3F8, 32'h3FC, 32'h400, 32'h404, 0, 0, 0, 0));
      vecs[7]  = mk(1'b0, 2'd2, 32'h0000_0044, 4'd1, 4'h8, 1'b0, 8'h01,       16'hFFFF,
                    a8(32'h44, 0, 0, 0, 0, 0, 0, 0));
      vecs[8]  = mk(1'b1, 2'd2, 32'h0000_03F8, 4'd4, 4'hF, 1'b0, 8'h01,       16'hFFFF,
                    a8(32'h3F8, 32'h3FC, 32'h3F0, 32'h3F4, 0, 0, 0, 0));
      vecs[9]  = mk(1'b0, 2'd1, 32'h0000_0000, 4'd0, 4'hF, 1'b1, 8'h00,       16'hFFFF,
                    a8(0, 0, 0, 0, 0, 0, 0, 0));
      vecs[10] = mk(1'b0, 2'd1, 32'h0000_0000, 4'd9, 4'hF, 1'b1, 8'h00,       16'hFFFF,
                    a8(0, 0, 0, 0, 0, 0, 0, 0));
      vecs[11] = mk(1'b0, 2'd2, 32'h0000_0000, 4'd3, 4'hF, 1'b1, 8'h00,       16'hFFFF,
                    a8(0, 0, 0, 0, 0, 0, 0, 0));
      vecs[12] = mk(1'b1, 2'd1, 32'h0000_0102, 4'd2, 4'hF, 1'b1, 8'h00,       16'hFFFF,
                    a8(0, 0, 0, 0, 0, 0, 0, 0));
      vecs[13] = mk(1'b1, 2'd3, 32'h0000_0100, 4'd2, 4'hF, 1'b1, 8'h00,       16'hFFFF,
                    a8(0, 0, 0, 0, 0, 0, 0, 0));

      rst_n        = 1'b0;
      req_valid    = 1'b0;
      req_write    = 1'b0;
      req_incr     = 2'd0;
      req_addr     = '0;
      req_len      = '0;
      req_byte_sel = '0;
      beat_ready   = 1'b1;
      #2;
      chk("rst_valid", beat_valid, 0);
      chk("rst_first", beat_first, 0);
      chk("rst_last", beat_last, 0);
      chk("rst_err", req_err, 0);
      chk("rst_addr", beat_addr, 0);
      chk("rst_idx", beat_idx, 0);
      chk("rst_bsel", beat_byte_sel, 0);
      chk("rst_write", beat_write, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_ready", req_ready, 1);

      // Garbage fields with req_valid low must be ignored
      req_incr = 2'd3;
      req_len  = 4'd0;
      req_addr = 32'h1;
      repeat (2) @(negedge clk);
      chk("idle_no_err", req_err, 0);
      chk("idle_no_beat", beat_valid, 0);

      for (int i = 0; i < NV; i++) run_vec(vecs[i]);

      // Reset in the middle of a 4-beat burst, at beat 2
      req_valid    = 1'b1;
      req_write    = 1'b1;
      req_incr     = 2'd1;
      req_addr     = 32'h200;
      req_len      = 4'd4;
      req_byte_sel = 4'hF;
      beat_ready   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      chk("mid_idx2", beat_idx, 2);
      chk("mid_addr2", beat_addr, 32'h208);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", beat_valid, 0);
      chk("mid_rst_idx", beat_idx, 0);
      chk("mid_rst_addr", beat_addr, 0);
      chk("mid_rst_err", req_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_valid", beat_valid, 0);
      chk("post_rst_err", req_err, 0);
      chk("post_rst_ready", req_ready, 1);

      run_vec(mk(1'b0, 2'd0, 32'h0000_0020, 4'd1, 4'h5, 1'b0, 8'h01, 16'hFFFF,
                 a8(32'h20, 0, 0, 0, 0, 0, 0, 0)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
